count_monitor: RTL and testbench
================================

# count_monitor

Receive-side checker for the free-running 8-bit counter our top level drives onto the dedicated output pins. A second die (or a loopback of the pins) presents that count on its dedicated inputs. `count_monitor` samples it and verifies that each sample is the previous value plus one, modulo 2^WIDTH. It reports lock status, flags each discontinuity, and keeps a saturating error tally that the top level can map onto `uo_out`.

## Interface
Parameters:
- `WIDTH`, 8: width of the monitored count.
- `LOCK_CNT`, 4: consecutive good increments required to declare lock (1..15).
- `ERR_W`, 8: width of the error counter.

Ports:
- `clk`  in  1: the only clock. One clock; reset is synchronous and active-high.
- `rst`  in  1: synchronous, active-high reset.
- `count_in`  in  WIDTH: observed count value.
- `count_valid`  in  1: `count_in` is sampled on cycles where this is high.
- `err_clr`  in  1: synchronous clear of `err_count`.
- `locked`  out  1: stream is verified continuous.
- `err_pulse`  out  1: one-cycle strobe marking a discontinuity while locked.
- `err_count`  out  ERR_W: saturating count of `err_pulse` events.
- `last_count`  out  WIDTH: most recently accepted sample.

## Operation
- States are HUNT, TRACK and LOCKED. Reset goes to HUNT.
- Expected value: `exp = last_count + 1`, truncated to WIDTH bits. 2^WIDTH−1 → 0 is therefore a legal increment.
- HUNT:
  - On `count_valid`, store the sample in `last_count`, clear the match counter and go to TRACK.
- TRACK:
  - On `count_valid` with sample == `exp`, increment the match counter.
  - When the match counter reaches `LOCK_CNT`, go to LOCKED.
  - On `count_valid` with sample != `exp`, clear the match counter and stay in TRACK (reseed from the sample).
  - No `err_pulse` is raised in TRACK.
- LOCKED:
  - On `count_valid` with sample == `exp`, stay in LOCKED.
  - On `count_valid` with sample != `exp`, assert `err_pulse`, increment `err_count`, clear the match counter, go to TRACK and reseed.
- Every `count_valid` sample updates `last_count`, regardless of state.
- Cycles with `count_valid` low do nothing: no state change and no timeout.
- `err_count` saturates at 2^ERR_W−1 and never wraps.
- `err_clr`:
  - Alone, it sets `err_count` to 0.
  - In the same cycle as an error, `err_count` becomes 1 (clear first, then count).
  - It does not affect state, `locked` or `last_count`.
- `locked` is high exactly when the state is LOCKED.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, `last_count`=0, state HUNT, match counter 0.
- All outputs are registered.
- A sample taken on edge N is reflected in `locked`, `err_pulse`, `err_count` and `last_count` after edge N. Comparison latency is one cycle.
- Lock timing: the first valid sample is a seed. `locked` rises after the (`LOCK_CNT`+1)th consecutive valid sample, where the last `LOCK_CNT` samples are each +1.
- `err_pulse` is high for exactly one cycle per bad sample.
- Back-to-back bad samples while in TRACK raise no further pulses.
- Reset asserted mid-stream overrides every input that cycle, including `count_valid` and `err_clr`.
- `count_in` is treated as synchronous to `clk`. Any synchronization for an off-die source is done outside this block.

## Configuration
- Macro: `COUNT_MONITOR_HOLD_EN`.
- Defined: a valid sample equal to `last_count` (counter stalled) is accepted as neither good nor bad. The match counter is unchanged, no `err_pulse` fires, and the state is held.
- Undefined: a repeated value is a mismatch and follows the normal mismatch rules.

## Structure
- Package `count_monitor_pkg` holds:
  - the state enum (HUNT, TRACK, LOCKED);
  - the default `WIDTH`, `LOCK_CNT` and `ERR_W` constants;
  - the match-counter width constant (4 bits).
- One sub-module, `sat_counter` (parameter `W`; ports `clk`, `rst`, `clr`, `inc`, `q`), implements `err_count` with the clear-then-increment rule above.
- The comparator and state machine live in `count_monitor`.

## Test plan
- Lock and wrap:
  - Stimulus: reset, then valid samples 250,251,...,255,0,1,2 on consecutive cycles.
  - Response: `locked` rises one cycle after sample 254; it stays high across 255→0; `err_count` stays 0.
- Single error:
  - Stimulus: while locked after value 10, present 12.
  - Response: `err_pulse` high for one cycle; `err_count`=1; `locked`=0; `last_count`=12.
  - Follow-up: samples 13..16 relock `locked` after 16.
- Saturation and clear:
  - Stimulus: with `ERR_W`=2, force 5 lock/error cycles.
  - Response: `err_count` holds at 3.
  - Stimulus: `err_clr` together with an error.
  - Response: `err_count`=1.
- Idle gaps:
  - Stimulus: locked stream 40,41,42 with 7 cycles of `count_valid`=0 between samples.
  - Response: `locked` remains 1; no `err_pulse`.
- Hold macro:
  - Stimulus: locked at 20, then sample 20.
  - Response with `COUNT_MONITOR_HOLD_EN` defined: no error, `locked`=1.
  - Response without it: `err_pulse`, `locked`=0.
- Reset mid-operation:
  - Stimulus: locked with `err_count`=3, assert `rst` for one cycle together with `count_valid`.
  - Response: all outputs return to reset values and the state is HUNT.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared types and default constants for count_monitor.
//   state_e    : HUNT / TRACK / LOCKED tracking states
//   DefWidth   : default monitored count width
//   DefLockCnt : default good increments needed to declare lock
//   DefErrW    : default error counter width
//   MatchW     : width of the consecutive-match counter (LOCK_CNT <= 15)
package count_monitor_pkg;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StTrack  = 2'd1,
    StLocked = 2'd2
  } state_e;

  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefLockCnt = 4;
  localparam int unsigned DefErrW    = 8;
  localparam int unsigned MatchW     = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk : clock
//   rst : synchronous active-high reset, q -> 0
//   clr : clear; when asserted with inc the result is 1 (clear, then count)
//   inc : count one event, holding at all-ones
//   q   : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr && inc) begin
      q_d = W'(1);
    end else if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_monitor.sv
// count_monitor: checks that a sampled count advances by exactly +1 (mod 2^WIDTH)
// per valid sample, reports lock, strobes on discontinuities while locked and keeps
// a saturating error tally.
//   clk         : clock
//   rst         : synchronous active-high reset
//   count_in    : observed count value
//   count_valid : sample count_in this cycle
//   err_clr     : clear err_count (an error in the same cycle leaves it at 1)
//   locked      : stream verified continuous
//   err_pulse   : one-cycle strobe per bad sample while locked
//   err_count   : saturating count of err_pulse events
//   last_count  : most recently accepted sample
// Optional build macro COUNT_MONITOR_HOLD_EN: a sample equal to last_count (stalled
// counter) is neither good nor bad and leaves state and match counter untouched.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned LOCK_CNT = DefLockCnt,
  parameter int unsigned ERR_W    = DefErrW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_count
);

  state_e              state_q, state_d;
  logic [MatchW-1:0]   match_q, match_d;
  logic [WIDTH-1:0]    last_q, last_d;
  logic [WIDTH-1:0]    exp_val;
  logic                locked_q;
  logic                pulse_q, pulse_d;
  logic                hit;
  logic                stall;

  // Wrap from all-ones to zero falls out of the truncated add.
  assign exp_val = last_q + WIDTH'(1);
  assign hit     = (count_in == exp_val);

`ifdef COUNT_MONITOR_HOLD_EN
  assign stall = (count_in == last_q);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    last_d  = last_q;
    pulse_d = 1'b0;
    if (count_valid) begin
      last_d = count_in;
      unique case (state_q)
        StHunt: begin
          match_d = '0;
          state_d = StTrack;
        end
        StTrack: begin
          if (!stall) begin
            if (hit) begin
              match_d = match_q + MatchW'(1);
              if (match_d == MatchW'(LOCK_CNT)) begin
                state_d = StLocked;
              end
            end else begin
              // Reseed from this sample; no strobe until lock is regained.
              match_d = '0;
            end
          end
        end
        StLocked: begin
          if (!stall && !hit) begin
            pulse_d = 1'b1;
            match_d = '0;
            state_d = StTrack;
          end
        end
        default: begin
          match_d = '0;
          state_d = StHunt;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHunt;
      match_q  <= '0;
      last_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      last_q   <= last_d;
      locked_q <= (state_d == StLocked);
      pulse_q  <= pulse_d;
    end
  end

  // Fed from the next-state strobe so err_count moves on the same edge as err_pulse.
  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (err_clr),
    .inc (pulse_d),
    .q   (err_count)
  );

  assign locked     = locked_q;
  assign err_pulse  = pulse_q;
  assign last_count = last_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: table-driven bench for count_monitor (WIDTH=8, LOCK_CNT=4, ERR_W=2).
// Expected outputs are queued when a vector is driven and popped after the edge.
module tb_count_monitor;

`ifdef COUNT_MONITOR_HOLD_EN
  localparam bit Hold = 1'b1;
`else
  localparam bit Hold = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] count_in = '0;
  logic       count_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic       locked;
  logic       err_pulse;
  logic [1:0] err_count;
  logic [7:0] last_count;

  always #5 clk = ~clk;

  count_monitor #(
    .WIDTH    (8),
    .LOCK_CNT (4),
    .ERR_W    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in    (count_in),
    .count_valid (count_valid),
    .err_clr     (err_clr),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .last_count  (last_count)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic       clr;
    logic [7:0] cin;
    logic       locked;
    logic       pulse;
    logic [1:0] err;
    logic [7:0] last;
  } vec_t;

  typedef struct {
    logic       locked;
    logic       pulse;
    logic [1:0] err;
    logic [7:0] last;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic v, input logic c, input logic [7:0] cin,
                     input logic lk, input logic p, input logic [1:0] e,
                     input logic [7:0] l);
    vec_t x;
    x.rst = r; x.valid = v; x.clr = c; x.cin = cin;
    x.locked = lk; x.pulse = p; x.err = e; x.last = l;
    vecs.push_back(x);
  endtask

  // Samples s..s+3 after a reseed: lock comes up on the fourth.
  task automatic add_relock(input logic [7:0] s, input logic [1:0] e);
    for (int k = 0; k < 4; k++) begin
      add(0, 1, 0, s + 8'(k), (k == 3), 0, e, s + 8'(k));
    end
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input int idx, input logic r, input logic v, input logic c,
                      input logic [7:0] cin, input logic lk, input logic p,
                      input logic [1:0] e, input logic [7:0] l);
    exp_t x;
    rst = r; count_valid = v; err_clr = c; count_in = cin;
    x.locked = lk; x.pulse = p; x.err = e; x.last = l;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check("locked", idx, 32'(locked), 32'(x.locked));
    check("err_pulse", idx, 32'(err_pulse), 32'(x.pulse));
    check("err_count", idx, 32'(err_count), 32'(x.err));
    check("last_count", idx, 32'(last_count), 32'(x.last));
  endtask

  initial begin
    // Reset with a valid sample present: reset wins.
    add(1, 1, 0, 8'd99, 0, 0, 0, 0);
    // Lock and wrap: seed 250, lock after 254, stay locked through 255 -> 0.
    add(0, 1, 0, 8'd250, 0, 0, 0, 8'd250);
    for (int k = 251; k <= 253; k++) add(0, 1, 0, 8'(k), 0, 0, 0, 8'(k));
    add(0, 1, 0, 8'd254, 1, 0, 0, 8'd254);
    add(0, 1, 0, 8'd255, 1, 0, 0, 8'd255);
    for (int k = 0; k <= 10; k++) add(0, 1, 0, 8'(k), 1, 0, 0, 8'(k));
    // Single error: 10 -> 12, then relock on 13..16.
    add(0, 1, 0, 8'd12, 0, 1, 1, 8'd12);
    add(0, 0, 0, 8'd0, 0, 0, 1, 8'd12);
    add_relock(8'd13, 1);
    // Error to 36, relock ending at 40, then 41 and 42 with 7 idle cycles between.
    add(0, 1, 0, 8'd36, 0, 1, 2, 8'd36);
    add_relock(8'd37, 2);
    for (int s = 41; s <= 42; s++) begin
      for (int k = 0; k < 7; k++) add(0, 0, 0, 8'hAA, 1, 0, 2, 8'(s - 1));
      add(0, 1, 0, 8'(s), 1, 0, 2, 8'(s));
    end
    // Repeated value while locked.
    add(0, 1, 0, 8'd42, Hold, !Hold, Hold ? 2'd2 : 2'd3, 8'd42);
    for (int k = 43; k <= 45; k++) add(0, 1, 0, 8'(k), Hold, 0, Hold ? 2'd2 : 2'd3, 8'(k));
    add(0, 1, 0, 8'd46, 1, 0, Hold ? 2'd2 : 2'd3, 8'd46);
    // Saturation at 3.
    add(0, 1, 0, 8'd0, 0, 1, 3, 8'd0);
    add(0, 1, 0, 8'd1, 0, 0, 3, 8'd1);
    add(0, 1, 0, 8'd2, 0, 0, 3, 8'd2);
    add(0, 1, 0, 8'd3, 0, 0, 3, 8'd3);
    add(0, 1, 0, 8'd4, 1, 0, 3, 8'd4);
    add(0, 1, 0, 8'd9, 0, 1, 3, 8'd9);
    add_relock(8'd10, 3);
    // Clear coinciding with an error leaves 1; clear alone gives 0.
    add(0, 1, 1, 8'd20, 0, 1, 1, 8'd20);
    add(0, 0, 1, 8'd0, 0, 0, 0, 8'd20);
    add_relock(8'd21, 0);
    add(0, 0, 1, 8'd0, 1, 0, 0, 8'd24);
    // Error, then a second bad sample in TRACK: no further pulse.
    add(0, 1, 0, 8'd30, 0, 1, 1, 8'd30);
    add(0, 1, 0, 8'd77, 0, 0, 1, 8'd77);
    add_relock(8'd78, 1);
    add(0, 1, 0, 8'd40, 0, 1, 2, 8'd40);
    add_relock(8'd41, 2);
    add(0, 1, 0, 8'd50, 0, 1, 3, 8'd50);
    add_relock(8'd51, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      step(i, vecs[i].rst, vecs[i].valid, vecs[i].clr, vecs[i].cin,
           vecs[i].locked, vecs[i].pulse, vecs[i].err, vecs[i].last);
    end

    // Reset mid-stream while locked with err_count=3, alongside valid and clear.
    step(1000, 1, 1, 1, 8'd55, 0, 0, 0, 8'd0);
    step(1001, 0, 0, 0, 8'd0, 0, 0, 0, 8'd0);
    // Back in HUNT: 77 seeds, lock only after four more increments.
    step(1002, 0, 1, 0, 8'd77, 0, 0, 0, 8'd77);
    step(1003, 0, 1, 0, 8'd78, 0, 0, 0, 8'd78);
    step(1004, 0, 1, 0, 8'd79, 0, 0, 0, 8'd79);
    step(1005, 0, 1, 0, 8'd80, 0, 0, 0, 8'd80);
    step(1006, 0, 1, 0, 8'd81, 1, 0, 0, 8'd81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
